// File: rtl/pipe_mux_pkg.sv
// Shared constants and helpers for the pipeline N-way registered selector.
package pipe_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  localparam int DEF_N         = 4;
  localparam int DEF_IN_WIDTH  = 9;
  localparam int DEF_OUT_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mux_stage_if.sv
// Channel-side and output-side handshake bundle of the pipeline selector.
interface pipe_mux_stage_if
  import pipe_mux_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SELW      = clog2(N)
);

  logic [N*IN_WIDTH-1:0] in_data;
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_ready;
  logic [SELW-1:0]       sel;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [SELW-1:0]       out_src;
  logic                  out_valid;
  logic                  out_ready;

  // slave is the selector itself, master is whatever surrounds it
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Output register plus one-entry skid; upstream ready is the registered skid-empty flag.
module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             load;

  assign in_ready = !skid_full;
  assign accept   = in_valid && in_ready;
  assign load     = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (load) begin
      // skid always holds the older word, so it drains before anything new
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mux_stage.sv
// N-way registered selector: explicit-select or round-robin grant, resize to OUT_WIDTH,
// then a skid-buffered output register carrying the word and its source channel.
module pipe_mux_stage
  import pipe_mux_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int MODE      = MODE_SEL
) (
  input logic             clk,
  input logic             rst,
  pipe_mux_stage_if.slave bus
);

  localparam int SELW = clog2(N);
  localparam int BW   = OUT_WIDTH + SELW;
  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [SELW-1:0]     rr_ptr;
  logic [SELW-1:0]     gnt;
  logic [SELW-1:0]     off;
  logic                gnt_vld;
  logic                buf_ready;
  logic                accept;
  logic [N-1:0]        rot;
  logic [SELW:0]       gsum;
  logic [SELW:0]       nsum;
  logic [IN_WIDTH-1:0] word;
  logic [BW-1:0]       buf_out;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    off     = '0;
    gsum    = '0;
    rot     = N'({bus.in_valid, bus.in_valid} >> rr_ptr);
    if (MODE == MODE_RR) begin
      // descending scan leaves the smallest offset from the pointer as winner
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) begin
          gnt_vld = 1'b1;
          off     = SELW'(k);
        end
      end
      gsum = {1'b0, rr_ptr} + {1'b0, off};
      gnt  = (gsum >= N_W) ? SELW'(gsum - N_W) : gsum[SELW-1:0];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) word = bus.in_data[i*IN_WIDTH +: IN_WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = gnt_vld && (gnt == SELW'(i)) && buf_ready && !rst;
    end
  end

  assign accept = gnt_vld && buf_ready && !rst;
  assign nsum   = {1'b0, gnt} + (SELW+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (nsum >= N_W) ? '0 : nsum[SELW-1:0];
    end
  end

  pipe_skid_buf #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({gnt, OUT_WIDTH'(word)}),
    .in_valid  (gnt_vld && !rst),
    .in_ready  (buf_ready),
    .out_data  (buf_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.out_src  = buf_out[BW-1 -: SELW];
  assign bus.out_data = buf_out[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Directed bench for pipe_mux_stage: select mode, round-robin, back-pressure, reset, widening.
module tb_pipe_mux_stage;
  import pipe_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_mux_stage_if #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(8))  s_if ();
  pipe_mux_stage_if #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(8))  r_if ();
  pipe_mux_stage_if #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(12)) w_if ();

  pipe_mux_stage #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(8), .MODE(MODE_SEL)) u_sel (
    .clk (clk), .rst (rst), .bus (s_if)
  );
  pipe_mux_stage #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(8), .MODE(MODE_RR)) u_rr (
    .clk (clk), .rst (rst), .bus (r_if)
  );
  pipe_mux_stage #(.N(4), .IN_WIDTH(9), .OUT_WIDTH(12), .MODE(MODE_SEL)) u_wide (
    .clk (clk), .rst (rst), .bus (w_if)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    int         w;
    int         rcv;
    int         occ;
    int         cyc;
    logic       acc;
    logic       xfer;
    logic       stall_prev;
    logic [7:0] held;

    rst = 1'b1;
    s_if.in_data = '0; s_if.in_valid = '0; s_if.sel = '0; s_if.out_ready = 1'b0;
    r_if.in_data = '0; r_if.in_valid = '0; r_if.sel = '0; r_if.out_ready = 1'b0;
    w_if.in_data = '0; w_if.in_valid = '0; w_if.sel = '0; w_if.out_ready = 1'b0;
    s_if.sel = 2'd2;
    s_if.in_valid = 4'b0100;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", s_if.out_valid, 0);
    chk("rst_out_data", s_if.out_data, 0);
    chk("rst_out_src", s_if.out_src, 0);
    chk("rst_in_ready", s_if.in_ready, 0);

    // explicit select of channel 2
    @(negedge clk);
    rst = 1'b0;
    s_if.in_data[2*9 +: 9] = 9'h1A5;
    s_if.out_ready = 1'b1;
    #1;
    chk("sel_in_ready", s_if.in_ready, 4'b0100);
    @(negedge clk);
    #1;
    chk("sel_out_data", s_if.out_data, 8'hA5);
    chk("sel_out_src", s_if.out_src, 2);
    chk("sel_out_valid", s_if.out_valid, 1);
    s_if.sel = 2'd1;
    #1;
    chk("sel_miss_ready", s_if.in_ready, 0);
    @(negedge clk);
    #1;
    chk("sel_miss_valid", s_if.out_valid, 0);
    s_if.in_valid = '0;

    // round-robin, all channels valid
    for (int i = 0; i < 4; i++) r_if.in_data[i*9 +: 9] = 9'(9'h105 + 16 * i);
    r_if.out_ready = 1'b1;
    r_if.in_valid  = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_in_ready", r_if.in_ready, 32'(1) << (k % 4));
      @(negedge clk);
      #1;
      chk("rr_src", r_if.out_src, k % 4);
      chk("rr_data", r_if.out_data, 16 * (k % 4) + 5);
      chk("rr_valid", r_if.out_valid, 1);
    end
    r_if.in_valid = '0;

    // back-pressure stream of 10 words on channel 0
    s_if.sel = 2'd0;
    w = 0; rcv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (rcv < 10 && cyc < 100) begin
      @(negedge clk);
      s_if.out_ready = (cyc % 3 == 0);
      s_if.in_valid  = (w < 10) ? 4'b0001 : 4'b0000;
      s_if.in_data[8:0] = 9'(w);
      #1;
      occ = w - rcv;
      if (stall_prev) chk("bp_hold", s_if.out_data, held);
      chk("bp_out_valid", s_if.out_valid, occ > 0);
      if (w < 10) chk("bp_in_ready", s_if.in_ready, (occ < 2) ? 1 : 0);
      acc  = s_if.in_valid[0] & s_if.in_ready[0];
      xfer = s_if.out_valid & s_if.out_ready;
      if (xfer) chk("bp_order", s_if.out_data, rcv);
      stall_prev = s_if.out_valid & !s_if.out_ready;
      held = s_if.out_data;
      w   += int'(acc);
      rcv += int'(xfer);
      cyc++;
    end
    chk("bp_count", rcv, 10);

    // fill output and skid, then reset mid-transfer
    @(negedge clk);
    s_if.out_ready = 1'b0;
    s_if.in_valid  = 4'b0001;
    s_if.in_data[8:0] = 9'h0AA;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("full_in_ready", s_if.in_ready, 0);
    chk("full_out_valid", s_if.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", s_if.out_valid, 0);
    chk("rst_mid_ready", s_if.in_ready, 0);
    chk("rst_mid_data", s_if.out_data, 0);
    chk("rst_mid_src", s_if.out_src, 0);

    @(negedge clk);
    rst = 1'b0;
    s_if.in_data[8:0] = 9'h05A;
    s_if.out_ready = 1'b1;
    r_if.in_valid  = 4'b1010;
    #1;
    chk("rel_in_ready", s_if.in_ready, 4'b0001);
    chk("rr_skip0", r_if.in_ready, 4'b0010);
    @(negedge clk);
    #1;
    chk("rel_out_data", s_if.out_data, 8'h5A);
    chk("rel_out_valid", s_if.out_valid, 1);
    chk("rr_skip_src1", r_if.out_src, 1);
    chk("rr_skip1", r_if.in_ready, 4'b1000);
    @(negedge clk);
    #1;
    chk("rr_skip_src3", r_if.out_src, 3);
    chk("rr_skip2", r_if.in_ready, 4'b0010);
    r_if.in_valid = '0;
    s_if.in_valid = '0;

    // zero-extension to 12 bits
    w_if.sel = 2'd0;
    w_if.in_data[8:0] = 9'h1FF;
    w_if.in_valid = 4'b0001;
    w_if.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("wide_data0", w_if.out_data, 12'h1FF);
    chk("wide_src0", w_if.out_src, 0);
    w_if.sel = 2'd3;
    w_if.in_data[3*9 +: 9] = 9'h1C3;
    w_if.in_valid = 4'b1000;
    @(negedge clk);
    #1;
    chk("wide_data3", w_if.out_data, 12'h1C3);
    chk("wide_src3", w_if.out_src, 3);
    w_if.in_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
